// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if: configuration, control and accumulator-drive bundle of the sweep controller
interface dds_sweep_ctrl_if #(
  parameter int ACC_LENGTH = 48,
  parameter int STEP_CNT_W = 16,
  parameter int DWELL_W = 24
);
  logic [ACC_LENGTH-1:0] cfg_start_freq;
  logic [ACC_LENGTH-1:0] cfg_step;
  logic [STEP_CNT_W-1:0] cfg_num_steps;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [1:0] cfg_mode;
  logic cfg_valid;
  logic cfg_ready;
  logic start;
  logic abort;
  logic busy;
  logic [ACC_LENGTH-1:0] increment;
  logic load_increment;
  logic [STEP_CNT_W-1:0] step_index;
  logic dir;
  logic sweep_done;
  modport master (
    output cfg_start_freq, cfg_step, cfg_num_steps, cfg_dwell, cfg_mode, cfg_valid, start, abort,
    input cfg_ready, busy, increment, load_increment, step_index, dir, sweep_done
  );
  modport slave (
    input cfg_start_freq, cfg_step, cfg_num_steps, cfg_dwell, cfg_mode, cfg_valid, start, abort,
    output cfg_ready, busy, increment, load_increment, step_index, dir, sweep_done
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS accumulator increment through single, sawtooth or triangle sweeps
module dds_sweep_ctrl #(
  parameter int ACC_LENGTH = 48,
  parameter int STEP_CNT_W = 16,
  parameter int DWELL_W = 24
) (
  input logic sys_clk,
  input logic sys_rst_n,
  dds_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DWELL, DONE} state_t;
  state_t state, nxt;
  logic [ACC_LENGTH-1:0] start_r, step_r;
  logic [STEP_CNT_W-1:0] n_r;
  logic [DWELL_W-1:0] d_r, cnt, rld;
  logic [1:0] mode_r;
  logic loaded, upd, tick, last, single, abort_now;
  assign rld = d_r - DWELL_W'(1);
  assign tick = state == DWELL && cnt == '0;
  assign last = bus.step_index == n_r;
  assign single = mode_r == 2'b00 || mode_r == 2'b11;
  assign abort_now = bus.abort && state != IDLE;
  assign bus.busy = state != IDLE;
  assign bus.cfg_ready = state == IDLE;
  assign bus.sweep_done = state == DONE;
  always_comb begin
    nxt = state;
    if (abort_now) nxt = IDLE;
    else if (state == IDLE) nxt = (bus.start && loaded && !bus.cfg_valid && !bus.abort) ? LOAD : IDLE;
    else if (state == LOAD) nxt = DWELL;
    else if (state == DONE) nxt = IDLE;
    else nxt = (tick && last && single) ? DONE : DWELL;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else state <= nxt;
  end
  // upd marks an increment update; the strobe follows one edge later so the value has settled
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      start_r <= '0;
      step_r <= '0;
      n_r <= '0;
      d_r <= DWELL_W'(2);
      mode_r <= '0;
      loaded <= 1'b0;
      cnt <= '0;
      upd <= 1'b0;
      bus.increment <= '0;
      bus.step_index <= '0;
      bus.dir <= 1'b0;
      bus.load_increment <= 1'b0;
    end else begin
      upd <= 1'b0;
      bus.load_increment <= upd && !abort_now;
      if (state == IDLE && bus.cfg_valid) begin
        start_r <= bus.cfg_start_freq;
        step_r <= bus.cfg_step;
        n_r <= bus.cfg_num_steps;
        d_r <= bus.cfg_dwell < DWELL_W'(2) ? DWELL_W'(2) : bus.cfg_dwell;
        mode_r <= bus.cfg_mode;
        loaded <= 1'b1;
      end
      if (!abort_now && state == LOAD) begin
        bus.increment <= start_r;
        bus.step_index <= '0;
        bus.dir <= 1'b0;
        cnt <= rld;
        upd <= 1'b1;
      end
      if (!abort_now && state == DWELL) begin
        cnt <= cnt - DWELL_W'(1);
        if (tick && !last) begin
          bus.increment <= bus.dir ? bus.increment - step_r : bus.increment + step_r;
          bus.step_index <= bus.step_index + STEP_CNT_W'(1);
          cnt <= rld;
          upd <= 1'b1;
        end else if (tick && !single) begin
          // triangle turnaround steps away immediately, so the peak value counts as index 0
          if (mode_r == 2'b10 && n_r != '0) begin
            bus.dir <= ~bus.dir;
            bus.increment <= bus.dir ? bus.increment + step_r : bus.increment - step_r;
            bus.step_index <= STEP_CNT_W'(1);
          end else begin
            bus.increment <= start_r;
            bus.step_index <= '0;
          end
          cnt <= rld;
          upd <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed scenario tests for the DDS sweep controller
module tb_dds_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass = 0;
  int total = 0;
  logic [47:0] sv [16];
  int sc [16];
  logic sd [16];
  int ns, nd, dc;
  bit dbl;
  dds_sweep_ctrl_if bus ();
  dds_sweep_ctrl dut (.sys_clk(clk), .sys_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [47:0] f, input logic [47:0] s, input logic [15:0] n, input logic [23:0] d, input logic [1:0] m);
    bus.cfg_start_freq = f;
    bus.cfg_step = s;
    bus.cfg_num_steps = n;
    bus.cfg_dwell = d;
    bus.cfg_mode = m;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
  endtask
  task automatic capture(input int n);
    logic prev;
    ns = 0; nd = 0; dc = -1; dbl = 0; prev = 1'b0;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (bus.load_increment) begin
        if (ns < 16) begin
          sv[ns] = bus.increment;
          sc[ns] = c;
          sd[ns] = bus.dir;
        end
        ns++;
        if (prev) dbl = 1;
      end
      prev = bus.load_increment;
      if (bus.sweep_done) begin
        nd++;
        dc = c;
      end
    end
  endtask
  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic test_reset();
    total++;
    if ({bus.busy, bus.cfg_ready, bus.load_increment, bus.sweep_done, bus.dir} !== 5'b01000 || bus.increment !== 48'h0 || bus.step_index !== 16'h0) $display("FAIL reset_vals busy/rdy/ld/done/dir=%b inc=%h idx=%0d want 01000 0 0", {bus.busy, bus.cfg_ready, bus.load_increment, bus.sweep_done, bus.dir}, bus.increment, bus.step_index);
    else pass++;
    #20 rst_n = 1'b1;
    tick();
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.busy !== 1'b0) $display("FAIL start_no_cfg busy=%b want 0", bus.busy);
      else pass++;
    end
    bus.start = 1'b0;
  endtask
  task automatic test_single();
    cfg(48'h1000, 48'h100, 16'd3, 24'd4, 2'b00);
    go();
    capture(20);
    total++;
    if (ns !== 4 || nd !== 1 || dc !== 17 || dbl !== 1'b0) $display("FAIL single_counts strobes=%0d done=%0d done_cyc=%0d dbl=%0d want 4 1 17 0", ns, nd, dc, dbl);
    else pass++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sv[i] !== 48'h1000 + 48'(i * 256) || sc[i] !== 2 + 4 * i) $display("FAIL single_strobe%0d inc=%h cyc=%0d want %h %0d", i, sv[i], sc[i], 48'h1000 + 48'(i * 256), 2 + 4 * i);
      else pass++;
    end
    total++;
    if (bus.busy !== 1'b0 || bus.increment !== 48'h1300) $display("FAIL single_end busy=%b inc=%h want 0 1300", bus.busy, bus.increment);
    else pass++;
  endtask
  task automatic test_min_dwell();
    for (int d = 0; d < 2; d++) begin
      cfg(48'h0, 48'h1, 16'd3, 24'(d), 2'b00);
      go();
      capture(12);
      total++;
      if (ns !== 4 || dc !== 9 || dbl !== 1'b0) $display("FAIL min_dwell%0d strobes=%0d done_cyc=%0d dbl=%0d want 4 9 0", d, ns, dc, dbl);
      else pass++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (sv[i] !== 48'(i) || sc[i] !== 2 + 2 * i) $display("FAIL min_dwell%0d_strobe%0d inc=%h cyc=%0d want %0d %0d", d, i, sv[i], sc[i], i, 2 + 2 * i);
        else pass++;
      end
    end
  endtask
  task automatic test_triangle();
    int ev [7] = '{10, 15, 20, 15, 10, 15, 20};
    logic ed [7] = '{0, 0, 0, 1, 1, 0, 0};
    cfg(48'd10, 48'd5, 16'd2, 24'd3, 2'b10);
    go();
    capture(22);
    total++;
    if (ns !== 7 || nd !== 0) $display("FAIL tri_counts strobes=%0d done=%0d want 7 0", ns, nd);
    else pass++;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (sv[i] !== 48'(ev[i]) || sd[i] !== ed[i] || sc[i] !== 2 + 3 * i) $display("FAIL tri_strobe%0d inc=%0d dir=%b cyc=%0d want %0d %b %0d", i, sv[i], sd[i], sc[i], ev[i], ed[i], 2 + 3 * i);
      else pass++;
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask
  task automatic test_wrap();
    cfg(48'h2, 48'hFFFF_FFFF_FFFD, 16'd1, 24'd2, 2'b01);
    go();
    capture(9);
    total++;
    if (ns !== 4 || nd !== 0) $display("FAIL wrap_counts strobes=%0d done=%0d want 4 0", ns, nd);
    else pass++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sv[i] !== (i % 2 == 0 ? 48'h2 : 48'hFFFF_FFFF_FFFF)) $display("FAIL wrap_strobe%0d inc=%h want %h", i, sv[i], (i % 2 == 0 ? 48'h2 : 48'hFFFF_FFFF_FFFF));
      else pass++;
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask
  task automatic test_abort();
    cfg(48'h1000, 48'h100, 16'd3, 24'd4, 2'b00);
    bus.start = 1'b1;
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    total++;
    if (bus.load_increment !== 1'b0 || bus.busy !== 1'b0 || bus.increment !== 48'h1000) $display("FAIL abort_pending ld=%b busy=%b inc=%h want 0 0 1000", bus.load_increment, bus.busy, bus.increment);
    else pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.load_increment !== 1'b0 || bus.busy !== 1'b0 || bus.sweep_done !== 1'b0) $display("FAIL abort_hold ld=%b busy=%b done=%b want 0 0 0", bus.load_increment, bus.busy, bus.sweep_done);
      else pass++;
    end
    bus.abort = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.load_increment !== 1'b0 || bus.busy !== 1'b0 || bus.sweep_done !== 1'b0 || bus.increment !== 48'h1000) $display("FAIL abort_dwell ld=%b busy=%b done=%b inc=%h want 0 0 0 1000", bus.load_increment, bus.busy, bus.sweep_done, bus.increment);
    else pass++;
    tick();
    bus.abort = 1'b0;
  endtask
  task automatic test_cfg_priority();
    cfg(48'h1000, 48'h100, 16'd3, 24'd4, 2'b00);
    go();
    tick();
    bus.cfg_start_freq = 48'h5000;
    bus.cfg_step = 48'h10;
    bus.cfg_num_steps = 16'd1;
    bus.cfg_valid = 1'b1;
    total++;
    if (bus.cfg_ready !== 1'b0) $display("FAIL cfg_busy ready=%b want 0", bus.cfg_ready);
    else pass++;
    tick();
    tick();
    bus.cfg_valid = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    total++;
    if (bus.cfg_ready !== 1'b1) $display("FAIL cfg_idle ready=%b want 1", bus.cfg_ready);
    else pass++;
    go();
    capture(20);
    total++;
    if (ns !== 4 || sv[0] !== 48'h1000 || sv[3] !== 48'h1300) $display("FAIL cfg_retained strobes=%0d first=%h last=%h want 4 1000 1300", ns, sv[0], sv[3]);
    else pass++;
    bus.cfg_valid = 1'b1;
    bus.start = 1'b1;
    tick();
    total++;
    if (bus.busy !== 1'b0) $display("FAIL cfg_start_same busy=%b want 0", bus.busy);
    else pass++;
    bus.cfg_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) $display("FAIL start_after_cfg busy=%b want 1", bus.busy);
    else pass++;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask
  task automatic test_async_reset();
    cfg(48'h1000, 48'h100, 16'd3, 24'd4, 2'b00);
    go();
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.cfg_ready, bus.load_increment, bus.sweep_done, bus.dir} !== 5'b01000 || bus.increment !== 48'h0 || bus.step_index !== 16'h0) $display("FAIL async_reset busy/rdy/ld/done/dir=%b inc=%h idx=%0d want 01000 0 0", {bus.busy, bus.cfg_ready, bus.load_increment, bus.sweep_done, bus.dir}, bus.increment, bus.step_index);
    else pass++;
    #3 rst_n = 1'b1;
    tick();
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.busy !== 1'b0) $display("FAIL reset_cfg_cleared busy=%b want 0", bus.busy);
      else pass++;
    end
    bus.start = 1'b0;
  endtask
  initial begin
    bus.cfg_start_freq = '0;
    bus.cfg_step = '0;
    bus.cfg_num_steps = '0;
    bus.cfg_dwell = '0;
    bus.cfg_mode = '0;
    bus.cfg_valid = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1;
    test_reset();
    test_single();
    test_min_dwell();
    test_triangle();
    test_wrap();
    test_abort();
    test_cfg_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
